fetch_queue: RTL and testbench

Parametrised instruction queue between the IF stage and the if2id register. It stores up to DEPTH fetched words together with their PC, fetch exception bits and delay-slot flag, so that instruction-side stalls and decode-side stalls no longer have to be locked together. It is flushed on exception, ERET or branch redirect. It presents a first-word-fall-through head entry to decode. When empty, the head it presents is a NOP.

---
 rtl/fetch_queue_pkg.sv | 29 ++
 rtl/fetch_queue_ram.sv | 30 +++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue.
// Holds the stored-entry layout {pc, instr, except, ds} and the NOP head value.
// The layout is packed MSB-first as pc | instr | except | ds, so ds sits at bit 0.
package fetch_queue_pkg;

  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Entry width and field offsets as functions of the instance widths.
  function automatic int entry_w(input int data_w, input int exc_w);
    return PC_W + data_w + exc_w + 1;
  endfunction

  function automatic int exc_off();
    return 1;
  endfunction

  function automatic int instr_off(input int exc_w);
    return 1 + exc_w;
  endfunction

  function automatic int pc_off(input int data_w, input int exc_w);
    return 1 + exc_w + data_w;
  endfunction

  localparam int DS_OFF  = 0;
  localparam int ENTRY_W = entry_w(32, 8);  // width at default parameters

endpackage

// File: rtl/fetch_queue_ram.sv
// fq_ram: DEPTH x W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk     clock
//   we_i    write enable
//   waddr_i write index
//   wdata_i write data
//   raddr_i read index
//   rdata_o read data (combinational)
module fq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 73,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through instruction queue between IF and the
// if2id register. Stores {pc, instr, except, ds}; flushed on redirect.
//   clk, rst              clock, synchronous active-high reset
//   flush_i               drop all contents (wins over push/pop)
//   push_*_i/push_ready_o IF side valid/ready plus entry fields
//   pop_ready_i/pop_*_o   decode side; head forced to zero (NOP) when empty
//   count_o               occupancy, almost_full_o = count_o >= AF_LEVEL
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int EXC_W    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [31:0]       push_pc_i,
  input  logic [DATA_W-1:0] push_instr_i,
  input  logic [EXC_W-1:0]  push_except_i,
  input  logic              push_ds_i,
  input  logic              pop_ready_i,
  output logic              pop_valid_o,
  output logic [31:0]       pop_pc_o,
  output logic [DATA_W-1:0] pop_instr_o,
  output logic [EXC_W-1:0]  pop_except_o,
  output logic              pop_ds_o,
  output logic [PW-1:0]     count_o,
  output logic              almost_full_o
);

  localparam int EW    = entry_w(DATA_W, EXC_W);
  localparam int EXO   = exc_off();
  localparam int INO   = instr_off(EXC_W);
  localparam int PCO   = pc_off(DATA_W, EXC_W);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          empty, full, push_fire, pop_fire;
  logic [EW-1:0] wdata, rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign almost_full_o = (count_o >= PW'(AF_LEVEL));

  // A full queue still accepts when decode drains the head in the same cycle.
  assign push_ready_o = !full || pop_ready_i;
  assign pop_valid_o  = !empty;

  assign push_fire = push_valid_i && push_ready_o && !flush_i;
  assign pop_fire  = pop_ready_i  && pop_valid_o  && !flush_i;

  assign wdata = {push_pc_i, push_instr_i, push_except_i, push_ds_i};

  fq_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .we_i    (push_fire),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // Head fields; stale storage is hidden behind a NOP when empty.
  assign pop_pc_o     = empty ? 32'h0           : rdata[PCO +: 32];
  assign pop_instr_o  = empty ? DATA_W'(NOP_INSTR) : rdata[INO +: DATA_W];
  assign pop_except_o = empty ? '0              : rdata[EXO +: EXC_W];
  assign pop_ds_o     = empty ? 1'b0            : rdata[DS_OFF];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;  // discard everything, keep write position
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_pc_i;
  logic [31:0] push_instr_i;
  logic [7:0]  push_except_i;
  logic        push_ds_i;
  logic        pop_ready_i;
  logic        pop_valid_o;
  logic [31:0] pop_pc_o;
  logic [31:0] pop_instr_o;
  logic [7:0]  pop_except_o;
  logic        pop_ds_o;
  logic [2:0]  count_o;
  logic        almost_full_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .DATA_W(32), .EXC_W(8), .AF_LEVEL(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .push_valid_i  (push_valid_i),
    .push_ready_o  (push_ready_o),
    .push_pc_i     (push_pc_i),
    .push_instr_i  (push_instr_i),
    .push_except_i (push_except_i),
    .push_ds_i     (push_ds_i),
    .pop_ready_i   (pop_ready_i),
    .pop_valid_o   (pop_valid_o),
    .pop_pc_o      (pop_pc_o),
    .pop_instr_o   (pop_instr_o),
    .pop_except_o  (pop_except_o),
    .pop_ds_o      (pop_ds_o),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        pr;
    logic        fl;
    int          e_cnt;
    logic        e_pv;
    logic [31:0] e_pc;
    logic        e_rdy;
    logic        e_af;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic pr,
                              input logic fl, input int c, input logic epv,
                              input logic [31:0] epc, input logic rdy, input logic af);
    vec_t v;
    v.pv = pv; v.pc = pc; v.pr = pr; v.fl = fl;
    v.e_cnt = c; v.e_pv = epv; v.e_pc = epc; v.e_rdy = rdy; v.e_af = af;
    return v;
  endfunction

  // Table entries derive instr/except/ds from the PC.
  task automatic drive(input logic pv, input logic [31:0] pc, input logic [7:0] exc,
                       input logic ds, input logic pr, input logic fl);
    push_valid_i  = pv;
    push_pc_i     = pc;
    push_instr_i  = ~pc;
    push_except_i = exc;
    push_ds_i     = ds;
    pop_ready_i   = pr;
    flush_i       = fl;
  endtask

  localparam logic [31:0] A = 32'hBFC0_0000;

  // Scoreboard for the streaming section.
  typedef struct { logic [31:0] pc; logic [7:0] exc; logic ds; } ent_t;
  ent_t sb[$];

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("reset count", 32'(count_o), 0);
    check("reset pop_valid", 32'(pop_valid_o), 0);
    check("reset pop_instr", pop_instr_o, 0);
    check("reset pop_pc", pop_pc_o, 0);
    check("reset push_ready", 32'(push_ready_o), 1);
    check("reset almost_full", 32'(almost_full_o), 0);

    // Expectations are the outputs seen with the row's inputs applied, before its edge.
    vt.push_back(mk(1, A+32'h00, 0, 0, 0, 0, 0,       1, 0));
    vt.push_back(mk(1, A+32'h04, 0, 0, 1, 1, A,       1, 0));
    vt.push_back(mk(1, A+32'h08, 0, 0, 2, 1, A,       1, 0));
    vt.push_back(mk(1, A+32'h0C, 0, 0, 3, 1, A,       1, 1));
    vt.push_back(mk(1, A+32'h10, 0, 0, 4, 1, A,       0, 1)); // full, held
    vt.push_back(mk(1, A+32'h10, 1, 0, 4, 1, A,       1, 1)); // push+pop when full
    vt.push_back(mk(0, 32'h0,    1, 0, 4, 1, A+32'h04, 1, 1));
    vt.push_back(mk(0, 32'h0,    1, 0, 3, 1, A+32'h08, 1, 1));
    vt.push_back(mk(0, 32'h0,    1, 0, 2, 1, A+32'h0C, 1, 0));
    vt.push_back(mk(0, 32'h0,    1, 0, 1, 1, A+32'h10, 1, 0));
    vt.push_back(mk(1, A+32'h14, 1, 0, 0, 0, 0,       1, 0)); // pop on empty ignored
    vt.push_back(mk(1, A+32'h18, 0, 0, 1, 1, A+32'h14, 1, 0));
    vt.push_back(mk(1, A+32'h1C, 0, 0, 2, 1, A+32'h14, 1, 0));
    vt.push_back(mk(1, A+32'h20, 1, 1, 3, 1, A+32'h14, 1, 1)); // flush drops push+pop
    vt.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0,       1, 0));
    vt.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0,       1, 0)); // flushed push never shows

    foreach (vt[i]) begin
      drive(vt[i].pv, vt[i].pc, vt[i].pc[9:2], vt[i].pc[2], vt[i].pr, vt[i].fl);
      #1;
      check($sformatf("vec%0d count", i), 32'(count_o), 32'(vt[i].e_cnt));
      check($sformatf("vec%0d pop_valid", i), 32'(pop_valid_o), 32'(vt[i].e_pv));
      check($sformatf("vec%0d pop_pc", i), pop_pc_o, vt[i].e_pc);
      check($sformatf("vec%0d pop_instr", i), pop_instr_o, vt[i].e_pv ? ~vt[i].e_pc : 32'h0);
      check($sformatf("vec%0d pop_except", i), 32'(pop_except_o),
            vt[i].e_pv ? 32'(vt[i].e_pc[9:2]) : 32'h0);
      check($sformatf("vec%0d pop_ds", i), 32'(pop_ds_o), vt[i].e_pv ? 32'(vt[i].e_pc[2]) : 32'h0);
      check($sformatf("vec%0d push_ready", i), 32'(push_ready_o), 32'(vt[i].e_rdy));
      check($sformatf("vec%0d almost_full", i), 32'(almost_full_o), 32'(vt[i].e_af));
      @(posedge clk); #1;
    end

    // Streaming with irregular pops: pointers wrap several times.
    begin
      int k = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        logic pv, pr, acc;
        ent_t e;
        pv = (cyc < 28) && (cyc % 5 != 4);
        pr = (cyc % 3 != 2);
        e.pc  = 32'h0000_1000 + 32'(k) * 4;
        e.exc = (k == 7) ? 8'h80 : 8'(k);
        e.ds  = k[0];
        drive(pv, e.pc, e.exc, e.ds, pr, 1'b0);
        #1;
        check($sformatf("wrap%0d count", cyc), 32'(count_o), 32'(sb.size()));
        if (sb.size() > 0) begin
          check($sformatf("wrap%0d pc", cyc), pop_pc_o, sb[0].pc);
          check($sformatf("wrap%0d instr", cyc), pop_instr_o, ~sb[0].pc);
          check($sformatf("wrap%0d except", cyc), 32'(pop_except_o), 32'(sb[0].exc));
          check($sformatf("wrap%0d ds", cyc), 32'(pop_ds_o), 32'(sb[0].ds));
        end
        acc = pv && ((sb.size() < 4) || pr);
        if (pr && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin sb.push_back(e); k++; end
        @(posedge clk); #1;
      end
      check("wrap drained", 32'(count_o), 0);
      check("wrap entries", 32'(k >= 20), 1);
    end

    // Push into empty with pop_ready held: no bypass, one-cycle latency.
    drive(1'b1, 32'hBFC0_0100, 8'h5A, 1'b1, 1'b1, 1'b0);
    #1;
    check("bypass pop_valid in push cycle", 32'(pop_valid_o), 0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    #1;
    check("bypass pop_valid next", 32'(pop_valid_o), 1);
    check("bypass pop_pc", pop_pc_o, 32'hBFC0_0100);
    check("bypass except", 32'(pop_except_o), 32'h5A);
    check("bypass ds", 32'(pop_ds_o), 1);
    @(posedge clk); #1;
    check("bypass popped", 32'(count_o), 0);

    // rst together with flush acts as reset.
    drive(1'b1, 32'h4, 8'h1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst+flush count", 32'(count_o), 0);
    check("rst+flush pop_valid", 32'(pop_valid_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
